// File: rtl/st_to_bin.sv
`timescale 1ns/1ps
// Stochastic-to-binary converter: counts 1s in a unipolar bitstream over WINDOW valid samples.
// Latency: final valid sample at edge t -> bin_out/out_valid visible in the cycle after t.
// Backpressure: none; st_valid gates sampling, idle cycles freeze the window.
module st_to_bin #(
  parameter int WIDTH      = 8,
  parameter int WINDOW     = 255,
  parameter int CONTINUOUS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             st_in,
  input  logic             st_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic             out_valid,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  // sample_cnt value at which the next valid sample closes the window
  localparam logic [WIDTH-1:0] LAST_SAMPLE = WIDTH'(WINDOW - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] ones_cnt;
  logic [WIDTH-1:0] sample_cnt;
  logic             complete;

  // a window closes on the valid sample that brings sample_cnt up to WINDOW
  assign complete = (state == ACCUM) && st_valid && (sample_cnt == LAST_SAMPLE);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state: start opens a window; completion stays in ACCUM if continuous or restarted
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (complete && (CONTINUOUS == 0) && !start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    busy = (state == ACCUM);
  end

  // window counters: held at zero while idle so entry to ACCUM starts clean;
  // completion and restart both clear, st_in of a restart cycle is dropped
  always_ff @(posedge clk) begin
    if (reset || state == IDLE || complete || start) begin
      ones_cnt   <= '0;
      sample_cnt <= '0;
    end else if (st_valid) begin
      ones_cnt   <= ones_cnt + WIDTH'(st_in);
      sample_cnt <= sample_cnt + 1'b1;
    end
  end

  // result publish: final sample is folded in directly so there is no extra cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= complete;
      if (complete) bin_out <= ones_cnt + WIDTH'(st_in);
    end
  end

endmodule

// File: tb/tb_st_to_bin.sv
`timescale 1ns/1ps
// Bench for st_to_bin: default one-shot instance (WINDOW 255) and a continuous WINDOW 4 instance.
// Expected counts come from the bench's own stream generators and a window-level reference model.
// Outputs are sampled 1ns after each rising edge; inputs are changed at the same point.
module tb_st_to_bin;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, st_in, st_valid;
  logic [7:0] bin_out;
  logic       out_valid, busy;
  logic       c_start, c_in, c_valid;
  logic [7:0] c_bin;
  logic       c_ovld, c_busy;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] last_bin = 8'd0;

  always #5 clk = ~clk;

  st_to_bin #(.WIDTH(8), .WINDOW(255), .CONTINUOUS(0)) dut (
    .clk(clk), .reset(reset), .start(start), .st_in(st_in), .st_valid(st_valid),
    .bin_out(bin_out), .out_valid(out_valid), .busy(busy));

  st_to_bin #(.WIDTH(8), .WINDOW(4), .CONTINUOUS(1)) dut_c (
    .clk(clk), .reset(reset), .start(c_start), .st_in(c_in), .st_valid(c_valid),
    .bin_out(c_bin), .out_valid(c_ovld), .busy(c_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start cycle then WINDOW valid samples of the chosen pattern.
  // kind: 0 all ones, 1 all zeros, 2 alternating from 1, 3 LFSR comparator stream for binv.
  // gap > 0 drops st_valid every gap-th cycle and puts noise on st_in there.
  task automatic feed(input int kind, input int binv, input int gap,
                      output int early, output logic fin_vld,
                      output logic [7:0] fin_bin, output logic fin_busy);
    logic [7:0] lfsr;
    int nv, c;
    logic b, v;
    lfsr = 8'd1; nv = 0; c = 0; early = 0;
    start = 1'b1; st_in = 1'b1; st_valid = 1'b1;
    tick();
    start = 1'b0;
    while (nv < 255) begin
      v = (gap == 0) || ((c % gap) != gap - 1);
      if (v) begin
        case (kind)
          0:       b = 1'b1;
          1:       b = 1'b0;
          2:       b = ((nv % 2) == 0);
          default: begin
            b = (lfsr < binv[7:0]);
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
          end
        endcase
        nv++;
      end else begin
        b = 1'($urandom % 2);
      end
      st_in = b; st_valid = v;
      tick();
      c++;
      if (nv < 255 && out_valid) early++;
    end
    fin_vld = out_valid; fin_bin = bin_out; fin_busy = busy;
    st_in = 1'b0; st_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; st_in = 0; st_valid = 0;
    c_start = 0; c_in = 0; c_valid = 0;
    tick(); tick();
    n_assert++; if (bin_out !== 8'd0) begin n_fail++; $display("FAIL reset_bin got %0d want 0", bin_out); end
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ovld got %b want 0", out_valid); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_assert++; if ({c_bin, c_ovld, c_busy} !== 10'd0) begin n_fail++; $display("FAIL reset_cont got %h want 0", {c_bin, c_ovld, c_busy}); end
    reset = 1'b0;
    tick();
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic check_window(input string name, input int kind, input int binv,
                              input int gap, input logic [7:0] want);
    int early; logic fv, fb; logic [7:0] bv;
    feed(kind, binv, gap, early, fv, bv, fb);
    n_assert++; if (early !== 0) begin n_fail++; $display("FAIL %s_early got %0d pulses want 0", name, early); end
    n_assert++; if (fv !== 1'b1) begin n_fail++; $display("FAIL %s_ovld got %b want 1", name, fv); end
    n_assert++; if (bv !== want) begin n_fail++; $display("FAIL %s_bin got %0d want %0d", name, bv, want); end
    n_assert++; if (fb !== 1'b0) begin n_fail++; $display("FAIL %s_busy got %b want 0", name, fb); end
    tick();
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_pulse_width got %b want 0", name, out_valid); end
    n_assert++; if (bin_out !== want) begin n_fail++; $display("FAIL %s_hold got %0d want %0d", name, bin_out, want); end
    last_bin = want;
  endtask

  task automatic test_patterns();
    check_window("ones", 0, 0, 0, 8'd255);
    check_window("zeros", 1, 0, 0, 8'd0);
    check_window("alt", 2, 0, 0, 8'd128);
  endtask

  task automatic test_lfsr_stream();
    check_window("lfsr100", 3, 100, 0, 8'd99);
    check_window("lfsr1", 3, 1, 0, 8'd0);
    check_window("lfsr128", 3, 128, 0, 8'd127);
    check_window("lfsr255", 3, 255, 0, 8'd254);
  endtask

  task automatic test_gaps();
    check_window("gap3", 2, 0, 3, 8'd128);
  endtask

  task automatic test_restart();
    int early;
    start = 1'b1; st_in = 1'b1; st_valid = 1'b1; tick(); start = 1'b0;
    early = 0;
    for (int i = 0; i < 100; i++) begin
      st_in = 1'b1; tick();
      if (out_valid) early++;
    end
    start = 1'b1; st_in = 1'b1; tick(); start = 1'b0;
    if (out_valid) early++;
    n_assert++; if (bin_out !== last_bin) begin n_fail++; $display("FAIL restart_hold got %0d want %0d", bin_out, last_bin); end
    n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got %b want 1", busy); end
    for (int i = 0; i < 254; i++) begin
      st_in = 1'b0; tick();
      if (out_valid) early++;
    end
    n_assert++; if (early !== 0) begin n_fail++; $display("FAIL restart_early got %0d pulses want 0", early); end
    st_in = 1'b0; tick();
    n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL restart_ovld got %b want 1", out_valid); end
    n_assert++; if (bin_out !== 8'd0) begin n_fail++; $display("FAIL restart_bin got %0d want 0", bin_out); end
    st_valid = 1'b0;
    last_bin = 8'd0;
    // reset mid-window after a nonzero result
    check_window("pre_rst", 0, 0, 0, 8'd255);
    start = 1'b1; st_in = 1'b1; st_valid = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n_assert++; if ({bin_out, out_valid, busy} !== 10'd0) begin n_fail++; $display("FAIL midrst_state got %h want 0", {bin_out, out_valid, busy}); end
    early = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (out_valid || busy) early++;
    end
    n_assert++; if (early !== 0) begin n_fail++; $display("FAIL midrst_after got %0d active cycles want 0", early); end
    st_valid = 1'b0; st_in = 1'b0;
    last_bin = 8'd0;
  endtask

  // cycle-by-cycle reference of window accounting for the one-shot instance
  task automatic test_random();
    bit active; int cnt, ones, errs; logic [7:0] exp_bin;
    logic s, b, v, exp_p;
    active = 0; cnt = 0; ones = 0; errs = 0; exp_bin = last_bin;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      v = ($urandom % 10) < 7;
      b = 1'($urandom % 2);
      exp_p = 1'b0;
      if (!active) begin
        s = ($urandom % 4) == 0;
        if (s) begin active = 1; cnt = 0; ones = 0; end
      end else if (v && cnt == 254) begin
        s = 1'($urandom % 2);
        exp_p = 1'b1; exp_bin = 8'(ones + int'(b)); cnt = 0; ones = 0; active = s;
      end else begin
        s = ($urandom % 1500) == 0;
        if (s) begin cnt = 0; ones = 0; end
        else if (v) begin cnt++; ones += int'(b); end
      end
      start = s; st_in = b; st_valid = v;
      tick();
      n_assert++;
      if ({out_valid, busy, bin_out} !== {exp_p, active, exp_bin}) begin
        n_fail++; errs++;
        if (errs < 20) $display("FAIL random cyc %0d got ovld=%b busy=%b bin=%0d want ovld=%b busy=%b bin=%0d",
                                cyc, out_valid, busy, bin_out, exp_p, active, exp_bin);
      end
    end
    start = 0; st_in = 0; st_valid = 0;
  endtask

  task automatic test_continuous();
    logic [11:0] stream;
    logic [7:0]  want [3];
    int pulses, errs, cnt, ones;
    logic b, v, s, exp_p;
    logic [7:0] exp_bin;
    stream = 12'b1111_1000_1011; // consumed LSB first: 1,1,0,1 | 0,0,0,1 | 1,1,1,1
    want[0] = 8'd3; want[1] = 8'd1; want[2] = 8'd4;
    c_start = 1'b1; c_in = 1'b1; c_valid = 1'b1; tick(); c_start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      c_in = stream[i]; tick();
      n_assert++;
      if (c_ovld !== ((i % 4) == 3)) begin n_fail++; $display("FAIL cont_pulse idx %0d got %b want %b", i, c_ovld, (i % 4) == 3); end
      if ((i % 4) == 3) begin
        n_assert++;
        if (c_bin !== want[i / 4]) begin n_fail++; $display("FAIL cont_bin win %0d got %0d want %0d", i / 4, c_bin, want[i / 4]); end
      end
      if (c_busy !== 1'b1) pulses++;
    end
    n_assert++; if (pulses !== 0) begin n_fail++; $display("FAIL cont_busy got %0d low cycles want 0", pulses); end
    // random continuous traffic with restarts
    cnt = 0; ones = 0; errs = 0; exp_bin = 8'd4;
    for (int cyc = 0; cyc < 400; cyc++) begin
      v = ($urandom % 4) != 0;
      b = 1'($urandom % 2);
      s = ($urandom % 8) == 0;
      exp_p = 1'b0;
      if (v && cnt == 3) begin exp_p = 1'b1; exp_bin = 8'(ones + int'(b)); cnt = 0; ones = 0; end
      else if (s) begin cnt = 0; ones = 0; end
      else if (v) begin cnt++; ones += int'(b); end
      c_start = s; c_in = b; c_valid = v;
      tick();
      n_assert++;
      if ({c_ovld, c_busy, c_bin} !== {exp_p, 1'b1, exp_bin}) begin
        n_fail++; errs++;
        if (errs < 20) $display("FAIL cont_random cyc %0d got ovld=%b busy=%b bin=%0d want ovld=%b busy=1 bin=%0d",
                                cyc, c_ovld, c_busy, c_bin, exp_p, exp_bin);
      end
    end
    c_start = 0; c_in = 0; c_valid = 0;
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_lfsr_stream();
    test_gaps();
    test_restart();
    test_random();
    test_continuous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/st_to_bin.md
Name: st_to_bin

Overview:
- Stochastic-to-binary converter; the decode counterpart of the team's binary-to-stochastic generator.
- Counts the 1s in a unipolar stochastic bitstream over a fixed window of WINDOW valid samples and publishes the count as an unsigned binary word.
- Sits at the output of stochastic arithmetic chains so results can be read back in binary.
- Supports one-shot conversions triggered by start, and continuous back-to-back windows.

Parameters:
- WIDTH, 8, width of bin_out and internal counters.
- WINDOW, 255, valid samples per conversion; legal range 1..2^WIDTH-1. 255 matches the 8-bit maximal LFSR period.
- CONTINUOUS, 0, 1 = start the next window automatically after each result; 0 = return to IDLE after each result.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  begin (or restart) a conversion window.
- st_in  input  1  stochastic bit.
- st_valid  input  1  st_in is sampled only when high.
- bin_out  output  WIDTH  count of 1s in the last completed window; held until the next completion.
- out_valid  output  1  single-cycle pulse when bin_out updates.
- busy  output  1  high while a window is accumulating.

Behaviour:
- Reset (synchronous, active-high, clk rising edge):
  - state = IDLE.
  - ones_cnt = 0, sample_cnt = 0.
  - bin_out = 0, out_valid = 0, busy = 0.
  - Reset has priority over every other input.
  - Reset mid-window discards the partial count and produces no out_valid.
- States:
  - IDLE: busy = 0. Goes to ACCUM on start = 1. Counters are cleared on entry to ACCUM. st_in is ignored in IDLE, including in the cycle start is sampled.
  - ACCUM: busy = 1. On each cycle with st_valid = 1:
    - sample_cnt increments;
    - ones_cnt increments by st_in.
  - Window completes on the valid sample that brings sample_cnt to WINDOW. At that clock edge:
    - bin_out <= ones_cnt + st_in (final sample included);
    - out_valid <= 1 for exactly one cycle;
    - counters are cleared;
    - next state is ACCUM if CONTINUOUS = 1 or start = 1 in that cycle, otherwise IDLE.
- Latency: the final valid sample at edge t makes bin_out/out_valid visible after edge t, i.e. on the cycle following t. No other delay.
- Continuous mode: no dead cycle between windows. The sample in the cycle after completion belongs to the new window.
- Restart: start = 1 in ACCUM while not completing clears both counters that cycle. st_in in that cycle is discarded. No out_valid; bin_out keeps its previous value.
- start = 1 in the completing cycle: the result is published normally and a new window begins; the two are not in conflict.
- st_valid = 0 cycles:
  - freeze both counters;
  - do not extend or shorten the window in samples.
- Arithmetic:
  - Counters are WIDTH bits, unsigned.
  - ones_cnt <= sample_cnt <= WINDOW <= 2^WIDTH-1, so no overflow or saturation logic exists.
  - bin_out range is 0..WINDOW.
- out_valid is low in every cycle except completion cycles. busy is combinational from state (state == ACCUM).

Test Plan:
- Reset, then start, then 255 valid cycles with st_in = 1 (WIDTH = 8, WINDOW = 255) -> out_valid pulses once, one cycle after the 255th sample; bin_out = 255; busy falls; state IDLE.
- Same with st_in = 0 for all samples -> bin_out = 0, out_valid single pulse. Alternating 1,0,1,... starting with 1 -> bin_out = 128.
- Feed the output of the binary-to-stochastic generator for bin = 100, with 255 samples aligned to the LFSR period -> bin_out = 99. Value range check across bin = 1, 128, 255 -> 0, 127, 254.
- Alternating 1,0,1,... with st_valid deasserted every 3rd cycle -> completion occurs after exactly 255 valid samples (~383 cycles); bin_out = 128; counters hold across gaps.
- Start, 100 samples of 1, then start again, then 255 samples of 0 -> no out_valid after the first 100 samples; single out_valid with bin_out = 0. Separately, reset asserted at sample 50 -> no out_valid, bin_out = 0, busy = 0.
- CONTINUOUS = 1, WINDOW = 4, stream 1,1,0,1 | 0,0,0,1 | 1,1,1,1 with st_valid always high -> out_valid on 3 cycles spaced exactly 4 apart; bin_out = 3, 1, 4; busy stays high throughout.
